// File: rtl/multi_cycle_mips.sv
// Multi-cycle MIPS subset core: IF -> ID -> EX -> {MEM} -> {WB}, one instruction in flight.
// Define MC_MIPS_IMM_EN to add addi/slti/andi/ori; otherwise those opcodes retire as nops.
module multi_cycle_mips #(
  parameter int unsigned MEM_ADDR_W = 7,
  parameter int unsigned MEM_LAT    = 1,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [31:0]           IR_addr,
  input  logic [31:0]           IR,
  input  logic [31:0]           ReadDataMem,
  output logic                  CEN,
  output logic                  WEN,
  output logic                  OEN,
  output logic [MEM_ADDR_W-1:0] A,
  output logic [31:0]           Data2Mem,
  output logic                  retire
);

`ifdef MC_MIPS_IMM_EN
  localparam bit ImmEn = 1'b1;
`else
  localparam bit ImmEn = 1'b0;
`endif

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnSll = 6'h00;
  localparam logic [5:0] FnSrl = 6'h02;
  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [2:0] {StIf, StId, StEx, StMem, StWb} state_e;

  state_e      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic [31:0] mdr;
  logic [3:0]  wait_cnt;
  logic [31:0] regs [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] tgt;
  logic [31:0] sext, zext, pc4, alu, next_pc;
  logic        is_r, is_jr, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_imm, is_short, taken;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign shamt = ir[10:6];
  assign funct = ir[5:0];
  assign imm   = ir[15:0];
  assign tgt   = ir[25:0];
  assign sext  = {{16{imm[15]}}, imm};
  assign zext  = {16'h0, imm};
  assign pc4   = pc + 32'd4;

  assign is_r   = (op == OpRtype) &&
                  (funct == FnAdd || funct == FnSub || funct == FnAnd || funct == FnOr ||
                   funct == FnSlt || funct == FnSll || funct == FnSrl);
  assign is_jr  = (op == OpRtype) && (funct == FnJr);
  assign is_lw  = (op == OpLw);
  assign is_sw  = (op == OpSw);
  assign is_beq = (op == OpBeq);
  assign is_bne = (op == OpBne);
  assign is_j   = (op == OpJ);
  assign is_jal = (op == OpJal);
  assign is_imm = ImmEn && (op == OpAddi || op == OpSlti || op == OpAndi || op == OpOri);
  // Branches, jumps and anything unrecognised all finish in EX.
  assign is_short = !(is_r || is_lw || is_sw || is_imm);
  assign taken    = (is_beq && (op_a == op_b)) || (is_bne && (op_a != op_b));

  assign IR_addr = pc;

  always_comb begin
    alu = 32'h0;
    if (is_r) begin
      case (funct)
        FnAdd:   alu = op_a + op_b;
        FnSub:   alu = op_a - op_b;
        FnAnd:   alu = op_a & op_b;
        FnOr:    alu = op_a | op_b;
        FnSlt:   alu = {31'h0, $signed(op_a) < $signed(op_b)};
        FnSll:   alu = op_b << shamt;
        FnSrl:   alu = op_b >> shamt;
        default: alu = 32'h0;
      endcase
    end else if (is_lw || is_sw) begin
      alu = op_a + sext;
    end else if (is_imm) begin
      case (op)
        OpAddi:  alu = op_a + sext;
        OpSlti:  alu = {31'h0, $signed(op_a) < $signed(sext)};
        OpAndi:  alu = op_a & zext;
        OpOri:   alu = op_a | zext;
        default: alu = 32'h0;
      endcase
    end
  end

  always_comb begin
    next_pc = pc4;
    if (is_jr) begin
      next_pc = op_a;
    end else if (is_j || is_jal) begin
      next_pc = {pc4[31:28], tgt, 2'b00};
    end else if (taken) begin
      next_pc = pc4 + {sext[29:0], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= StIf;
      pc       <= RESET_PC;
      ir       <= 32'h0;
      op_a     <= 32'h0;
      op_b     <= 32'h0;
      alu_res  <= 32'h0;
      mdr      <= 32'h0;
      wait_cnt <= 4'h0;
      CEN      <= 1'b1;
      WEN      <= 1'b1;
      OEN      <= 1'b1;
      A        <= '0;
      Data2Mem <= 32'h0;
      retire   <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0;
      end
    end else begin
      // retire is raised on the transition into an instruction's final cycle.
      retire <= 1'b0;
      case (state)
        StIf: begin
          ir    <= IR;
          state <= StId;
        end
        StId: begin
          op_a   <= (rs == 5'd0) ? 32'h0 : regs[rs];
          op_b   <= (rt == 5'd0) ? 32'h0 : regs[rt];
          state  <= StEx;
          retire <= is_short;
        end
        StEx: begin
          alu_res <= alu;
          if (is_short) begin
            pc    <= next_pc;
            state <= StIf;
            if (is_jal) begin
              regs[31] <= pc4;
            end
          end else if (is_lw || is_sw) begin
            state    <= StMem;
            wait_cnt <= 4'(MEM_LAT - 1);
            CEN      <= 1'b0;
            OEN      <= !is_lw;
            WEN      <= !is_sw;
            A        <= alu[MEM_ADDR_W+1:2];
            Data2Mem <= op_b;
            retire   <= is_sw && (MEM_LAT == 1);
          end else begin
            state  <= StWb;
            retire <= 1'b1;
          end
        end
        StMem: begin
          if (wait_cnt == 4'd0) begin
            CEN <= 1'b1;
            OEN <= 1'b1;
            WEN <= 1'b1;
            mdr <= ReadDataMem;
            if (is_sw) begin
              pc    <= pc4;
              state <= StIf;
            end else begin
              state  <= StWb;
              retire <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
            retire   <= is_sw && (wait_cnt == 4'd1);
          end
        end
        StWb: begin
          if (is_lw) begin
            if (rt != 5'd0) regs[rt] <= mdr;
          end else if (is_imm) begin
            if (rt != 5'd0) regs[rt] <= alu_res;
          end else begin
            if (rd != 5'd0) regs[rd] <= alu_res;
          end
          pc    <= pc4;
          state <= StIf;
        end
        default: state <= StIf;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_mips.sv
// Bench for multi_cycle_mips: ISA-level model checked every cycle plus directed literal checks.
module tb_multi_cycle_mips;
  localparam int unsigned LAT = 3;
  localparam int unsigned AW  = 7;
  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [31:0] MASK = (32'h1 << AW) - 32'h1;
`ifdef MC_MIPS_IMM_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  localparam logic [5:0] OpJal = 6'h03, OpBeq = 6'h04, OpBne = 6'h05, OpAddi = 6'h08;
  localparam logic [5:0] OpSlti = 6'h0A, OpAndi = 6'h0C, OpOri = 6'h0D;
  localparam logic [5:0] OpLw = 6'h23, OpSw = 6'h2B;
  localparam logic [5:0] FnSll = 6'h00, FnSrl = 6'h02, FnJr = 6'h08, FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22, FnAnd = 6'h24, FnOr = 6'h25, FnSlt = 6'h2A;

  logic          clk, rst_n;
  logic [31:0]   IR_addr, IR, ReadDataMem, Data2Mem;
  logic          CEN, WEN, OEN, retire;
  logic [AW-1:0] A;

  logic [31:0] imem [256];
  logic [31:0] dmem [128];
  logic [31:0] init_mem [128];
  logic        do_load;
  int          wr_cnt;

  int total, bad;
  bit run;
  logic [31:0] m_pc;
  logic [31:0] m_regs [32];
  logic [31:0] m_mem [128];

  multi_cycle_mips #(.MEM_ADDR_W(AW), .MEM_LAT(LAT), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .IR_addr(IR_addr), .IR(IR), .ReadDataMem(ReadDataMem),
    .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(Data2Mem), .retire(retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign IR          = imem[IR_addr[9:2]];
  assign ReadDataMem = (!CEN && !OEN) ? dmem[A] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (do_load) begin
      dmem <= init_mem;
    end else if (!CEN && !WEN) begin
      dmem[A] <= Data2Mem;
      wr_cnt  <= wr_cnt + 1;
    end
  end

  function automatic logic [31:0] r_op(input logic [5:0] fn, input int rd, input int rs,
                                       input int rt, input int sh);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input int rt, input int rs,
                                       input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  // Cycles an instruction occupies, straight from the ISA timing table.
  function automatic int ilen(input logic [31:0] w);
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    if (op == 6'h00)
      return (fn inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt, FnSll, FnSrl}) ? 4 : 3;
    if (op == OpLw) return 4 + LAT;
    if (op == OpSw) return 3 + LAT;
    if (op inside {OpAddi, OpSlti, OpAndi, OpOri}) return IMM_EN ? 4 : 3;
    return 3;
  endfunction

  task automatic mexec(input logic [31:0] w);
    logic [31:0] a, b, se, ze, npc;
    int rs, rt, rd, sh, idx;
    rs = int'(w[25:21]);
    rt = int'(w[20:16]);
    rd = int'(w[15:11]);
    sh = int'(w[10:6]);
    a = m_regs[rs];
    b = m_regs[rt];
    se = {{16{w[15]}}, w[15:0]};
    ze = {16'h0, w[15:0]};
    npc = m_pc + 32'd4;
    idx = int'(((a + se) >> 2) & MASK);
    case (w[31:26])
      6'h00: begin
        case (w[5:0])
          FnAdd: m_regs[rd] = a + b;
          FnSub: m_regs[rd] = a - b;
          FnAnd: m_regs[rd] = a & b;
          FnOr:  m_regs[rd] = a | b;
          FnSlt: m_regs[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          FnSll: m_regs[rd] = b << sh;
          FnSrl: m_regs[rd] = b >> sh;
          FnJr:  npc = a;
          default: ;
        endcase
      end
      OpLw: m_regs[rt] = m_mem[idx];
      OpSw: m_mem[idx] = b;
      OpBeq: if (a == b) npc = npc + (se << 2);
      OpBne: if (a != b) npc = npc + (se << 2);
      6'h02: npc = {npc[31:28], w[25:0], 2'b00};
      OpJal: begin
        m_regs[31] = npc;
        npc = {npc[31:28], w[25:0], 2'b00};
      end
      OpAddi: if (IMM_EN) m_regs[rt] = a + se;
      OpSlti: if (IMM_EN) m_regs[rt] = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
      OpAndi: if (IMM_EN) m_regs[rt] = a & ze;
      OpOri:  if (IMM_EN) m_regs[rt] = a | ze;
      default: ;
    endcase
    m_regs[0] = 32'h0;
    m_pc = npc;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    logic [31:0] cur, se;
    int n, k;
    bit is_l, is_s, win;
    k = 1;
    forever begin
      @(negedge clk);
      if (!run) begin
        m_pc = RST_PC;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_mem = init_mem;
        k = 1;
      end else begin
        cur  = imem[m_pc[9:2]];
        n    = ilen(cur);
        is_l = (cur[31:26] == OpLw);
        is_s = (cur[31:26] == OpSw);
        se   = {{16{cur[15]}}, cur[15:0]};
        win  = (is_l || is_s) && k >= 4 && k <= 3 + LAT;
        chk("ir_addr", IR_addr, m_pc);
        chk("retire", {31'h0, retire}, {31'h0, k == n});
        chk("cen", {31'h0, CEN}, {31'h0, !win});
        chk("oen", {31'h0, OEN}, {31'h0, !(win && is_l)});
        chk("wen", {31'h0, WEN}, {31'h0, !(win && is_s)});
        if (win) begin
          chk("mem_addr", {25'h0, A}, ((m_regs[cur[25:21]] + se) >> 2) & MASK);
          chk("wdata", Data2Mem, m_regs[cur[20:16]]);
        end
        if (k == n) begin
          mexec(cur);
          k = 1;
        end else begin
          k++;
        end
      end
    end
  endtask

  task automatic start_phase();
    run = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    for (int i = 0; i < 128; i++) init_mem[i] = 32'h0;
  endtask

  task automatic do_reset();
    do_load = 1'b1;
    @(posedge clk);
    #1 do_load = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ir_addr", IR_addr, RST_PC);
    chk("rst_strobes", {29'h0, CEN, WEN, OEN}, 32'h7);
    chk("rst_retire", {31'h0, retire}, 32'h0);
    chk("rst_a", {25'h0, A}, 32'h0);
    chk("rst_wdata", Data2Mem, 32'h0);
    rst_n = 1'b1;
    run = 1'b1;
  endtask

  task automatic run_instrs(input int n, output int cyc);
    int seen;
    seen = 0;
    cyc = 0;
    while (seen < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (retire) seen++;
    end
    if (seen < n) begin
      total++;
      bad++;
      $display("FAIL timeout: retired %0d of %0d", seen, n);
    end
  endtask

  task automatic next_addr(output logic [31:0] a);
    @(negedge clk);
    a = IR_addr;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cyc, hits, wr0;
    logic [31:0] na;
    total = 0;
    bad = 0;
    wr_cnt = 0;
    do_load = 1'b0;
    start_phase();
    fork
      compare_loop();
    join_none

    // lw with 3-cycle memory, then store the result back to observe it
    start_phase();
    init_mem[0] = 32'h1234;
    imem[0] = i_op(OpLw, 1, 0, 16'd0);
    imem[1] = i_op(OpSw, 1, 0, 16'd8);
    do_reset();
    run_instrs(1, cyc);
    chk("lw_cycles", cyc, 7);
    run_instrs(1, cyc);
    chk("sw_cycles", cyc, 6);
    settle();
    chk("lw_data", dmem[2], 32'h1234);

    // ALU ops, store results, write to $0 discarded
    start_phase();
    init_mem[3] = 32'd5;
    init_mem[4] = 32'd7;
    init_mem[5] = 32'h55;
    init_mem[12] = 32'h77;
    imem[0]  = i_op(OpLw, 1, 0, 16'd12);
    imem[1]  = i_op(OpLw, 2, 0, 16'd16);
    imem[2]  = r_op(FnAdd, 3, 1, 2, 0);
    imem[3]  = r_op(FnSlt, 4, 2, 1, 0);
    imem[4]  = i_op(OpSw, 3, 0, 16'd4);
    imem[5]  = i_op(OpSw, 4, 0, 16'd20);
    imem[6]  = r_op(FnSub, 6, 1, 2, 0);
    imem[7]  = r_op(FnSlt, 7, 6, 1, 0);
    imem[8]  = r_op(FnSll, 8, 0, 2, 4);
    imem[9]  = r_op(FnSrl, 9, 0, 6, 28);
    imem[10] = r_op(FnAnd, 10, 1, 2, 0);
    imem[11] = r_op(FnOr, 11, 1, 2, 0);
    for (int i = 0; i < 6; i++) imem[12 + i] = i_op(OpSw, 6 + i, 0, 16'(24 + 4 * i));
    imem[18] = r_op(FnAdd, 0, 1, 2, 0);
    imem[19] = i_op(OpSw, 0, 0, 16'd48);
    do_reset();
    run_instrs(20, cyc);
    settle();
    chk("add_mem1", dmem[1], 32'd12);
    chk("slt_false", dmem[5], 32'd0);
    chk("sub_wrap", dmem[6], 32'hFFFF_FFFE);
    chk("slt_signed", dmem[7], 32'd1);
    chk("sll", dmem[8], 32'h70);
    chk("srl", dmem[9], 32'hF);
    chk("and", dmem[10], 32'd5);
    chk("or", dmem[11], 32'd7);
    chk("r0_zero", dmem[12], 32'd0);

    // beq taken then bne not taken, both at PC 0x10
    for (int p = 0; p < 2; p++) begin
      start_phase();
      init_mem[8] = 32'd9;
      imem[0] = i_op(OpLw, 1, 0, 16'd32);
      imem[1] = i_op(OpLw, 2, 0, 16'd32);
      imem[4] = i_op((p == 0) ? OpBeq : OpBne, 2, 1, 16'd2);
      do_reset();
      run_instrs(5, cyc);
      next_addr(na);
      chk((p == 0) ? "beq_target" : "bne_fallthru", na, (p == 0) ? 32'h1C : 32'h14);
    end

    // jal / jr round trip
    start_phase();
    imem[2]  = {OpJal, 26'h40};
    imem[64] = r_op(FnJr, 0, 31, 0, 0);
    imem[3]  = i_op(OpSw, 31, 0, 16'd0);
    do_reset();
    run_instrs(3, cyc);
    next_addr(na);
    chk("jal_target", na, 32'h100);
    run_instrs(1, cyc);
    next_addr(na);
    chk("jr_target", na, 32'hC);
    run_instrs(1, cyc);
    settle();
    chk("jal_link", dmem[0], 32'hC);

    // immediate ops (or nops when disabled) and unsupported encodings
    start_phase();
    imem[0]  = i_op(OpAddi, 5, 0, 16'hFFFF);
    imem[1]  = i_op(OpSw, 5, 0, 16'd0);
    imem[2]  = i_op(OpOri, 6, 0, 16'h8000);
    imem[3]  = i_op(OpSw, 6, 0, 16'd4);
    imem[4]  = i_op(OpSlti, 7, 5, 16'd0);
    imem[5]  = i_op(OpSw, 7, 0, 16'd8);
    imem[6]  = i_op(OpAndi, 8, 5, 16'h00F0);
    imem[7]  = i_op(OpSw, 8, 0, 16'd12);
    imem[8]  = i_op(6'h3F, 5, 0, 16'h1234);
    imem[9]  = r_op(6'h3F, 5, 0, 0, 0);
    imem[10] = i_op(OpSw, 5, 0, 16'd16);
    do_reset();
    run_instrs(1, cyc);
    chk("addi_cycles", cyc, IMM_EN ? 32'd4 : 32'd3);
    run_instrs(10, cyc);
    settle();
    chk("addi_val", dmem[0], IMM_EN ? 32'hFFFF_FFFF : 32'h0);
    chk("ori_zext", dmem[1], IMM_EN ? 32'h8000 : 32'h0);
    chk("slti_val", dmem[2], IMM_EN ? 32'd1 : 32'd0);
    chk("andi_zext", dmem[3], IMM_EN ? 32'hF0 : 32'h0);
    chk("bad_op_nop", dmem[4], IMM_EN ? 32'hFFFF_FFFF : 32'h0);

    // reset during the second MEM cycle of a store
    start_phase();
    init_mem[1] = 32'hAB;
    imem[0] = i_op(OpLw, 1, 0, 16'd4);
    imem[1] = i_op(OpSw, 1, 0, 16'd8);
    do_reset();
    wr0 = wr_cnt;
    run_instrs(1, cyc);
    hits = 0;
    for (int c = 0; c < 50 && hits < 2; c++) begin
      @(negedge clk);
      if (!CEN && !WEN) hits++;
    end
    chk("sw_mem_cycles_seen", hits, 2);
    run = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_wen", {31'h0, WEN}, 32'h1);
    chk("abort_cen", {31'h0, CEN}, 32'h1);
    chk("abort_pc", IR_addr, RST_PC);
    chk("abort_retire", {31'h0, retire}, 32'h0);
    chk("abort_a", {25'h0, A}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_writes", wr_cnt - wr0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
